cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Eight-phase control state machine for the 8-bit RISC CPU.
- Consumes the latched instruction opcode and sequences fetch, execute and store across instruction memory, accumulator and data memory.
- Drives the program counter's enable, issuing one PC update per instruction. The PC computes JMP/SKZ/HLT next-address itself.
- Also provides halt detection, single-step gating and a retired-instruction counter.

Parameters:
- RETIRE_W, 8, width of retired-instruction counter.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = sequencer advances; 0 = freeze phase and force strobes low.
- step_mode  input  1  1 = hold in phase 0 until step.
- step  input  1  single-cycle advance request, sampled in phase 0 only.
- opcode  input  3  instruction register opcode: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- phase  output  3  current phase 0..7.
- sel  output  1  address mux: 1 = PC, 0 = IR operand.
- rd  output  1  memory read strobe.
- ld_ir  output  1  instruction register load.
- pc_en  output  1  program counter update enable, one cycle per instruction.
- ld_ac  output  1  accumulator load.
- wr  output  1  data memory write.
- data_e  output  1  accumulator drives data bus.
- halt  output  1  sticky halted flag.
- retired  output  RETIRE_W  count of completed non-HLT instructions.

Behaviour:
- Reset (reset=0, asynchronous):
  - phase=0, halt=0, retired=0.
  - All strobes 0. sel=0 during reset.
  - After release, first active edge applies phase-0 decode.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Phase decode (combinational from phase and opcode; all unlisted strobes 0):
  - 0 INST_ADDR: sel=1.
  - 1 INST_FETCH: sel=1, rd=1.
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - 3 IDLE: sel=1, rd=1, ld_ir=1.
  - 4 OP_ADDR: pc_en = (opcode!=HLT).
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP, data_e=(opcode==STO).
  - 7 STORE: rd=ALUOP, ld_ac=ALUOP, wr=(opcode==STO), data_e=(opcode==STO).
- Opcode is only meaningful from phase 4 onward. Phases 0-3 decode ignores it.
- Advance rule (per rising edge, enable=1, halt=0):
  - phase 0 -> 1 only if step_mode=0 or step=1; otherwise hold phase 0.
  - Phases 1..6 -> phase+1 unconditionally.
  - 7 -> 0, with retired+1 (wraps all-ones -> 0).
  - Phase 4 with opcode=HLT: halt<=1, phase held at 4, no retire.
- Halted state:
  - halt=1, phase=4, all strobes 0 including pc_en.
  - Ignores enable, step and opcode. Exit only via reset.
- enable=0: phase, retired and halt hold; all strobes forced 0, sel forced 0. On re-enable, resume same phase.
- step while step_mode=0: ignored.
- step held high across multiple cycles: advances one instruction per pass through phase 0; no edge detect.
- step_mode toggled mid-instruction: takes effect at next phase 0.
- JMP and SKZ:
  - Sequencer treats both as non-ALU; pc_en pulses in phase 4 only.
  - SKZ skip and JMP target are resolved by the PC.
- Latency: 8 cycles per instruction in free-running mode. The PC update lands at the end of phase 4.
- Reset asserted mid-instruction: immediate return to reset values; partially executed STO produces no further wr.

Test Plan:
- Reset: hold reset=0 with enable=1 -> phase=0, halt=0, retired=0, all strobes 0. Release -> phase steps 0,1,..,7,0 on successive edges.
- LDA (opcode=101) free-run:
  - pc_en=1 only in phase 4.
  - rd=1 in phases 1,2,3,5,6,7.
  - ld_ac=1 only in phase 7; wr=0 throughout; retired 0->1 at 7->0.
- STO (opcode=110): data_e=1 in phases 6,7; wr=1 only in phase 7; rd=0 and ld_ac=0 in phases 5-7.
- HLT (opcode=000) at phase 4:
  - pc_en=0, halt=1, phase stuck at 4 for 20 cycles, retired unchanged.
  - Toggling enable/step has no effect; reset clears halt.
- Step mode: step_mode=1, step=0 -> phase holds 0 for 10 cycles with sel=1. One-cycle step=1 -> one full instruction, then hold at 0 again.
- Wrap and freeze:
  - Run 256 ADD instructions -> retired wraps 255->0.
  - enable=0 in phase 6 for 5 cycles -> strobes 0, phase stays 6; resumes at 7.
  - reset=0 asserted in phase 7 of STO -> wr drops asynchronously.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: opcode in, datapath strobes out between the sequencer and the CPU datapath.
interface cpu_sequencer_if;
   logic [2:0] opcode;
   logic       sel;
   logic       rd;
   logic       ld_ir;
   logic       pc_en;
   logic       ld_ac;
   logic       wr;
   logic       data_e;
   modport master (input opcode, output sel, rd, ld_ir, pc_en, ld_ac, wr, data_e);
   modport slave (output opcode, input sel, rd, ld_ir, pc_en, ld_ac, wr, data_e);
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: eight-phase fetch/execute/store control FSM for the 8-bit RISC CPU,
// with a sticky halt, single-step gating and a retired-instruction counter.
module cpu_sequencer #(
   parameter int RETIRE_W = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                step_mode,
   input  logic                step,
   cpu_sequencer_if.master     bus,
   output logic [2:0]          phase,
   output logic                halt,
   output logic [RETIRE_W-1:0] retired
);
   typedef enum logic [2:0] {
      INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
   } state_t;
   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   state_t              state_q, state_d;
   logic                halt_d, adv, on, hlt, alu_op, sto;
   logic [RETIRE_W-1:0] retired_d;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state_q <= INST_ADDR;
         halt    <= 1'b0;
         retired <= '0;
      end else begin
         state_q <= state_d;
         halt    <= halt_d;
         retired <= retired_d;
      end
   // reset is folded into the strobe gate so every strobe, sel included, drops the moment reset asserts
   always_comb begin
      adv         = enable && !halt;
      on          = reset && adv;
      hlt         = state_q == OP_ADDR && bus.opcode == OP_HLT;
      alu_op      = bus.opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
      sto         = bus.opcode == OP_STO;
      state_d     = state_q;
      if (adv && !hlt && (state_q != INST_ADDR || !step_mode || step))
         state_d = state_t'(state_q + 3'd1);
      halt_d      = halt || (adv && hlt);
      retired_d   = retired + RETIRE_W'(adv && state_q == STORE);
      bus.sel     = on && state_q <= IDLE;
      bus.rd      = on && ((state_q >= INST_FETCH && state_q <= IDLE) || (state_q >= OP_FETCH && alu_op));
      bus.ld_ir   = on && (state_q == INST_LOAD || state_q == IDLE);
      bus.pc_en   = on && state_q == OP_ADDR && bus.opcode != OP_HLT;
      bus.ld_ac   = on && state_q == STORE && alu_op;
      bus.wr      = on && state_q == STORE && sto;
      bus.data_e  = on && (state_q == ALU_OP || state_q == STORE) && sto;
   end
   assign phase = state_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed sequence against a phase-table model; expected outputs are queued
// when stimulus is applied and compared after the DUT reacts.
module tb_cpu_sequencer;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b1;
   logic       step_mode = 1'b0;
   logic       step = 1'b0;
   logic [2:0] phase;
   logic       halt;
   logic [7:0] retired;
   int         vectors = 0;
   int         miscompares = 0;

   typedef struct {
      logic [2:0] ph;
      logic       h;
      logic [7:0] r;
      logic [6:0] s;
   } exp_t;
   exp_t q[$];

   int         mp = 0;
   bit         mh = 1'b0;
   logic [7:0] mr = 8'd0;

   cpu_sequencer_if bus();
   cpu_sequencer #(.RETIRE_W(8)) dut (
      .clock(clock), .reset(reset), .enable(enable), .step_mode(step_mode), .step(step),
      .bus(bus), .phase(phase), .halt(halt), .retired(retired)
   );

   always #5 clock = ~clock;

   // strobe order: {sel, rd, ld_ir, pc_en, ld_ac, wr, data_e}
   function automatic exp_t expect_now();
      exp_t e;
      logic [2:0] op;
      bit alu, st;
      op  = bus.opcode;
      alu = (op == 3'd2 || op == 3'd3 || op == 3'd4 || op == 3'd5);
      st  = (op == 3'd6);
      case (mp)
         0:       e.s = 7'b1000000;
         1:       e.s = 7'b1100000;
         2, 3:    e.s = 7'b1110000;
         4:       e.s = {3'b000, op != 3'd0, 3'b000};
         5:       e.s = {1'b0, alu, 5'b00000};
         6:       e.s = {1'b0, alu, 4'b0000, st};
         default: e.s = {1'b0, alu, 2'b00, alu, st, st};
      endcase
      if (!reset || !enable || mh) e.s = 7'b0;
      e.ph = 3'(mp);
      e.h  = mh;
      e.r  = mr;
      return e;
   endfunction

   task automatic model_edge();
      if (!reset) begin
         mp = 0; mh = 1'b0; mr = 8'd0;
      end else if (enable && !mh) begin
         if (mp == 4 && bus.opcode == 3'd0) mh = 1'b1;
         else if (mp == 0) begin
            if (!step_mode || step) mp = 1;
         end else if (mp == 7) begin
            mp = 0; mr = mr + 8'd1;
         end else mp = mp + 1;
      end
   endtask

   task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare(input string tag);
      exp_t e;
      e = q.pop_front();
      cmp({tag, ".phase"}, {5'b0, phase}, {5'b0, e.ph});
      cmp({tag, ".halt"}, {7'b0, halt}, {7'b0, e.h});
      cmp({tag, ".retired"}, retired, e.r);
      cmp({tag, ".strobes"},
          {1'b0, bus.sel, bus.rd, bus.ld_ir, bus.pc_en, bus.ld_ac, bus.wr, bus.data_e},
          {1'b0, e.s});
   endtask

   task automatic tick(input string tag);
      model_edge();
      q.push_back(expect_now());
      @(posedge clock);
      #1;
      compare(tag);
   endtask

   task automatic check_now(input string tag);
      if (!reset) begin
         mp = 0; mh = 1'b0; mr = 8'd0;
      end
      q.push_back(expect_now());
      #1;
      compare(tag);
   endtask

   task automatic run_to(input int ph, input string tag);
      for (int i = 0; i < 16 && mp != ph; i++) tick(tag);
   endtask

   initial begin
      bus.opcode = 3'b101;
      check_now("rst_hold");
      repeat (3) tick("rst_hold_clk");
      reset = 1'b1;
      check_now("rst_release");
      repeat (8) tick("lda");
      bus.opcode = 3'b110;
      repeat (8) tick("sto");
      bus.opcode = 3'b010;
      repeat (8) tick("add");
      bus.opcode = 3'b111;
      repeat (8) tick("jmp");
      bus.opcode = 3'b001;
      step = 1'b1;
      repeat (8) tick("skz_step_ignored");
      step = 1'b0;
      bus.opcode = 3'b110;
      run_to(6, "frz_pre");
      enable = 1'b0;
      repeat (5) tick("frz_hold");
      enable = 1'b1;
      tick("frz_resume");
      run_to(0, "frz_post");
      step_mode = 1'b1;
      bus.opcode = 3'b011;
      repeat (10) tick("step_hold");
      step = 1'b1;
      tick("step_go");
      step = 1'b0;
      repeat (7) tick("step_run");
      repeat (3) tick("step_rehold");
      step = 1'b1;
      repeat (16) tick("step_held");
      step = 1'b0;
      step = 1'b1;
      tick("step_mid");
      step = 1'b0;
      run_to(3, "step_mid");
      step_mode = 1'b0;
      run_to(0, "step_mid_exit");
      tick("free_again");
      run_to(0, "free_again");
      for (int n = 0; n < 256; n++) begin
         bus.opcode = 3'($urandom_range(1, 7));
         repeat (8) tick("wrap");
      end
      bus.opcode = 3'b110;
      run_to(7, "sto_rst");
      reset = 1'b0;
      check_now("sto_rst_async");
      tick("sto_rst_clk");
      reset = 1'b1;
      tick("sto_rst_after");
      bus.opcode = 3'b000;
      run_to(4, "hlt_enter");
      tick("hlt_latch");
      for (int i = 0; i < 20; i++) begin
         enable = 1'($urandom_range(0, 1));
         step = 1'($urandom_range(0, 1));
         step_mode = 1'($urandom_range(0, 1));
         bus.opcode = 3'($urandom_range(0, 7));
         tick("hlt_stuck");
      end
      enable = 1'b1; step = 1'b0; step_mode = 1'b0;
      reset = 1'b0;
      check_now("hlt_rst");
      tick("hlt_rst_clk");
      reset = 1'b1;
      bus.opcode = 3'b101;
      repeat (8) tick("post_hlt");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
